// File: rtl/parity_frame_rx_if.sv
// Serial-side and parallel-side signals of the parity frame receiver.
// The receiver is the slave; whoever drives the line and sample strobe is the master.
interface parity_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic             sample_en;
  logic             rx_in;
  logic [WIDTH-1:0] data_out;
  logic             parity_out;
  logic             frame_valid;
  logic             framing_error;
  logic             busy;

  modport master (
    output sample_en, rx_in,
    input  data_out, parity_out, frame_valid, framing_error, busy
  );

  modport slave (
    input  sample_en, rx_in,
    output data_out, parity_out, frame_valid, framing_error, busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// LSB-first start/data/parity/stop deserializer driven by an external sample strobe.
// frame_valid/framing_error are registered one-cycle pulses after the stop sample; no backpressure.
module parity_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  parity_frame_rx_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             parity_q, parity_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    parity_d = parity_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    if (bus.sample_en) begin
      case (state_q)
        IDLE: begin
          if (!bus.rx_in) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          // Shift in at the MSB so the first data bit ends up at bit 0.
          shift_d = {bus.rx_in, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = bus.rx_in;
          state_d = STOP;
        end
        STOP: begin
          if (bus.rx_in) begin
            data_d   = shift_q;
            parity_d = par_q;
            valid_d  = 1'b1;
          end else begin
            ferr_d   = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.parity_out    = parity_q;
  assign bus.frame_valid   = valid_q;
  assign bus.framing_error = ferr_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: directed scenarios plus random frames against a frame-level model.
module tb_parity_frame_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  parity_frame_rx_if #(.WIDTH(W)) bus ();

  parity_frame_rx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed pulses, collected away from the active edge.
  logic [W:0] mon_q[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) mon_q.push_back({bus.parity_out, bus.data_out});
    if (bus.framing_error === 1'b1) ferr_cnt++;
    if (bus.frame_valid === 1'b1 && bus.framing_error === 1'b1) both_cnt++;
  end

  // Downstream even-parity checker: error when the parity bit disagrees with the data's parity.
  function automatic logic checker_err(input logic [W-1:0] d, input logic p);
    return logic'(($countones(d) % 2) != int'(p));
  endfunction

  task automatic sample_bit(input logic b, input int gap);
    repeat (gap - 1) @(negedge clk);
    bus.rx_in     = b;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop_b,
                            input int gap_max);
    sample_bit(1'b0, $urandom_range(gap_max, 1));
    for (int i = 0; i < W; i++) sample_bit(d[i], $urandom_range(gap_max, 1));
    sample_bit(p, $urandom_range(gap_max, 1));
    sample_bit(stop_b, $urandom_range(gap_max, 1));
  endtask

  task automatic test_reset;
    bus.sample_en = 1'b0;
    bus.rx_in     = 1'b1;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.data_out, bus.parity_out, bus.frame_valid, bus.framing_error, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: got data=%h par=%b fv=%b fe=%b busy=%b, want all 0",
               bus.data_out, bus.parity_out, bus.frame_valid, bus.framing_error, bus.busy);
    end
    for (int i = 0; i < 20; i++) begin
      sample_bit(1'b1, 4);
      checks++;
      if ({bus.data_out, bus.parity_out, bus.frame_valid, bus.framing_error, bus.busy} !== '0) begin
        errors++;
        $display("FAIL idle_sample%0d: got data=%h par=%b fv=%b fe=%b busy=%b, want all 0", i,
                 bus.data_out, bus.parity_out, bus.frame_valid, bus.framing_error, bus.busy);
      end
    end
  endtask

  task automatic test_good_frame;
    int base = mon_q.size();
    int fbase = ferr_cnt;
    sample_bit(1'b0, 2);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", bus.busy);
    end
    for (int i = 0; i < W; i++) sample_bit(logic'((8'hA5 >> i) & 1), 3);
    sample_bit(1'b0, 2);
    sample_bit(1'b1, 2);
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL good_valid_latency: got fv=%b want 1 right after stop sample", bus.frame_valid);
    end
    @(negedge clk);
    checks++;
    if (mon_q.size() != base + 1 || mon_q[base] !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL good_frame: got %0d pulses last=%h, want 1 pulse of {0,a5}",
               mon_q.size() - base, mon_q.size() > base ? mon_q[mon_q.size()-1] : '0);
    end
    checks++;
    if (ferr_cnt != fbase || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL good_no_ferr: got ferr=%0d busy=%b want 0/0", ferr_cnt - fbase, bus.busy);
    end
    checks++;
    if (checker_err(bus.data_out, bus.parity_out) !== 1'b0) begin
      errors++;
      $display("FAIL good_checker: got error_flag 1 want 0");
    end
  endtask

  task automatic test_bad_parity;
    int base = mon_q.size();
    send_frame(8'h3C, 1'b1, 1'b1, 3);
    @(negedge clk);
    checks++;
    if (mon_q.size() != base + 1 || bus.data_out !== 8'h3C || bus.parity_out !== 1'b1) begin
      errors++;
      $display("FAIL bad_parity_pass: got %0d pulses data=%h par=%b want 1/3c/1",
               mon_q.size() - base, bus.data_out, bus.parity_out);
    end
    checks++;
    if (checker_err(bus.data_out, bus.parity_out) !== 1'b1) begin
      errors++;
      $display("FAIL bad_parity_checker: got error_flag 0 want 1");
    end
  endtask

  task automatic test_framing_error;
    int base = mon_q.size();
    int fbase = ferr_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 3);
    checks++;
    if (bus.framing_error !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_pulse: got fe=%b busy=%b want 1/0", bus.framing_error, bus.busy);
    end
    // A further high sample must leave the receiver idle: the low stop bit is not a start bit.
    sample_bit(1'b1, 2);
    @(negedge clk);
    checks++;
    if (ferr_cnt != fbase + 1 || mon_q.size() != base || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_count: got ferr=%0d valid=%0d busy=%b want 1/0/0",
               ferr_cnt - fbase, mon_q.size() - base, bus.busy);
    end
    checks++;
    if (bus.data_out !== 8'h3C || bus.parity_out !== 1'b1) begin
      errors++;
      $display("FAIL ferr_hold: got data=%h par=%b want 3c/1", bus.data_out, bus.parity_out);
    end
  endtask

  task automatic test_back_to_back;
    int base = mon_q.size();
    send_frame(8'h01, 1'b1, 1'b1, 5);
    send_frame(8'h80, 1'b1, 1'b1, 5);
    @(negedge clk);
    checks++;
    if (mon_q.size() != base + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses want 2", mon_q.size() - base);
    end else begin
      checks++;
      if (mon_q[base] !== {1'b1, 8'h01} || mon_q[base+1] !== {1'b1, 8'h80}) begin
        errors++;
        $display("FAIL b2b_data: got %h,%h want 101,180", mon_q[base], mon_q[base+1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int base = mon_q.size();
    int fbase = ferr_cnt;
    sample_bit(1'b0, 2);
    for (int i = 0; i < 4; i++) sample_bit(logic'((8'h55 >> i) & 1), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.data_out, bus.parity_out, bus.frame_valid, bus.framing_error, bus.busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: got data=%h par=%b fv=%b fe=%b busy=%b want all 0",
               bus.data_out, bus.parity_out, bus.frame_valid, bus.framing_error, bus.busy);
    end
    send_frame(8'h12, 1'b0, 1'b1, 3);
    @(negedge clk);
    checks++;
    if (mon_q.size() != base + 1 || ferr_cnt != fbase || mon_q[base] !== {1'b0, 8'h12}) begin
      errors++;
      $display("FAIL mid_reset_recover: got %0d pulses ferr=%0d data=%h want 1/0/12",
               mon_q.size() - base, ferr_cnt - fbase, bus.data_out);
    end
  endtask

  task automatic test_random;
    int base = mon_q.size();
    int fbase = ferr_cnt;
    int exp_ferr = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_good = {bus.parity_out, bus.data_out};
    logic [W-1:0] d;
    logic p, s;
    for (int f = 0; f < 30; f++) begin
      for (int k = $urandom_range(2, 0); k > 0; k--) sample_bit(1'b1, $urandom_range(3, 1));
      d = W'($urandom);
      p = logic'($urandom_range(1, 0));
      s = ($urandom_range(9, 0) != 0);
      send_frame(d, p, s, 3);
      if (s) begin
        exp_q.push_back({p, d});
        last_good = {p, d};
      end else begin
        exp_ferr++;
      end
    end
    @(negedge clk);
    checks++;
    if (mon_q.size() - base != exp_q.size() || ferr_cnt - fbase != exp_ferr) begin
      errors++;
      $display("FAIL rand_counts: got valid=%0d ferr=%0d want %0d/%0d",
               mon_q.size() - base, ferr_cnt - fbase, exp_q.size(), exp_ferr);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (mon_q[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_frame%0d: got %h want %h", i, mon_q[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({bus.parity_out, bus.data_out} !== last_good) begin
      errors++;
      $display("FAIL rand_hold: got %h want %h", {bus.parity_out, bus.data_out}, last_good);
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", both_cnt);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.rx_in     = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial frame receiver that sits directly upstream of the parity checker.
- Deserializes an LSB-first frame: start bit, WIDTH data bits, one parity bit, stop bit.
- Presents the captured data and parity bit as a parallel word with a one-cycle valid strobe, which drive the checker's data_in/parity_bit.
- Bit timing comes from an external sample strobe; the block does no oversampling or baud generation.

Parameters:
- WIDTH, 8, number of data bits per frame; legal range 2..32.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  one-cycle strobe; rx_in is sampled only in cycles where sample_en=1.
- rx_in  input  1  serial line, idle high.
- data_out  output  WIDTH  last good frame's data bits; bit 0 = first received data bit.
- parity_out  output  1  last good frame's received parity bit, unmodified.
- frame_valid  output  1  one-cycle pulse: data_out/parity_out updated with a new frame.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while the FSM is in DATA, PARITY or STOP.

Behaviour:
- Clock and reset: single clock domain (clk); reset is synchronous and active-high (rst). rst=1 at a rising edge overrides all other inputs.
- Reset values: state=IDLE, bit counter=0, shift register=0, data_out=0, parity_out=0, frame_valid=0, framing_error=0, busy=0.
- Reset mid-frame: the partial frame is discarded, no valid or error pulse is produced, and data_out/parity_out return to 0.
- State advance: all transitions happen only on cycles with sample_en=1. When sample_en=0 the state, counter and shift register hold, and frame_valid/framing_error are 0.
- State IDLE:
  - rx_in=1: stay in IDLE.
  - rx_in=0: start bit seen; clear the bit counter and go to DATA.
- State DATA:
  - Shift rx_in into the shift register MSB end, shifting right, so that after WIDTH samples the first bit is at bit 0.
  - Increment the counter each sample.
  - After the sample with counter==WIDTH-1, go to PARITY.
- State PARITY: capture rx_in into a parity holding register; go to STOP.
- State STOP, rx_in=1: on the same clock edge load data_out←shift register and parity_out←parity register, pulse frame_valid=1 for exactly one cycle, and return to IDLE.
- State STOP, rx_in=0: pulse framing_error=1 for exactly one cycle, leave data_out/parity_out unchanged, and return to IDLE. The low stop bit is not reused as a new start bit.
- Latency: frame_valid goes high in the clock cycle immediately after the edge on which the stop bit is sampled. Outputs are registered.
- Output hold: data_out/parity_out hold their value until the next good frame, so the downstream checker sees stable inputs.
- Mutual exclusion: frame_valid and framing_error are never high in the same cycle.
- busy: registered; equals (state != IDLE).
- Parity: the block does not evaluate parity. The even-parity check (error when parity bit ≠ XOR of data) is the downstream checker's job.
- Back-to-back frames: a start bit may be sampled on the very next sample_en after the stop sample. No idle gap is required.
- Counter width: the bit counter is sized to hold WIDTH-1 and must not wrap before the transition out of DATA.
- Glitch on start: no start-bit revalidation is done. A single low sample in IDLE starts a frame.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rx_in=1 with sample_en pulsing every 4 clk for 20 samples → all outputs 0 and busy=0 throughout.
- Good frame: WIDTH=8, send 0, data 0xA5 LSB first, parity 0, stop 1 → one frame_valid pulse, data_out=0xA5, parity_out=0, framing_error never high; downstream checker error_flag=0.
- Bad parity passthrough: send data 0x3C with parity 1 → frame_valid, data_out=0x3C, parity_out=1; checker error_flag=1. Confirms the parity bit is passed through unmodified.
- Framing error: send data 0xFF, parity 0, stop 0 → framing_error pulses once, frame_valid stays 0, data_out keeps the previous value (0x3C).
- Back-to-back with sample_en gaps: frames 0x01 then 0x80 with no idle bit between, sample_en irregular (1-5 clk spacing) → two frame_valid pulses carrying 0x01 then 0x80.
- Reset mid-frame: assert rst after 4 data bits of 0x55 → outputs return to 0, busy=0, no pulse; a following good frame 0x12 is received correctly.
